picoblaze_led_pwm: RTL and testbench
====================================

// Module: picoblaze_led_pwm
// PURPOSE
//  PicoBlaze (kcpsm6) output-port peripheral sitting directly downstream of the processor's
//  port_id/out_port/write_strobe bus. Holds one 8-bit duty register per LED and drives
//  glitch-free PWM on the LED pins. Also returns register contents on the in_port read path.
//  Replaces the single-bit "grab out_port[0]" LED latch with addressable, dimmable outputs.
// PARAMETERS
//  NUM_LEDS   8      number of PWM LED outputs, 1..14
//  BASE_PORT  8'h00  first port_id of the register window
//  PRESCALE   16     iClk cycles per PWM phase step, >=1
// PORTS
//  iClk          in   1         system clock, shared with kcpsm6
//  iResetN       in   1         asynchronous, active-low reset
//  iPortId       in   8         kcpsm6 port_id
//  iOutPort      in   8         kcpsm6 out_port
//  iWriteStrobe  in   1         kcpsm6 write_strobe (OUTPUT)
//  iKWriteStrobe in   1         kcpsm6 k_write_strobe (OUTPUTK)
//  oInPort       out  8         registered read data to kcpsm6 in_port
//  oLed          out  NUM_LEDS  PWM LED outputs
// BEHAVIOUR
//  Register map (offset = port_id - BASE_PORT):
//   0..NUM_LEDS-1  DUTY[i] shadow, R/W
//   NUM_LEDS       CTRL R/W: bit0 EN, bit1 INV (active-low LEDs), bits7:2 read 0
//   NUM_LEDS+1     STATUS RO: current phase counter
//   others         writes ignored, reads 8'h00
//  Writes: iWriteStrobe decodes the full 8-bit iPortId. iKWriteStrobe decodes iPortId[3:0]
//   against BASE_PORT[3:0] only. Register updates on the rising edge where the strobe is high.
//   If both strobes are high in one cycle, iWriteStrobe decode wins.
//  Reads: every cycle oInPort <= mux(iPortId). Latency is 1 cycle, which meets kcpsm6
//   INPUT timing. No read side effects.
//  Prescaler: pre counts 0..PRESCALE-1; tick = (pre==PRESCALE-1) & EN. At tick, pre wraps to 0.
//  Phase: 8-bit counter. Increments on tick; wraps 255->0.
//  Shadow->active: at a tick with phase==255, all DUTY shadows are copied to active duties.
//   A write in that same cycle lands in the shadow only; it takes effect at the next wrap.
//  Output: led_raw[i] = (phase < active[i]), registered. oLed = led_raw ^ {NUM_LEDS{INV}}.
//   Duty 0 gives always off. Duty 255 gives 255/256 on. Duty change never truncates the
//   current period.
//  EN=0: pre and phase are held at 0. Active duties are loaded directly from the shadows
//   each cycle. led_raw = 0, so oLed = all INV.
//  EN 0->1: first tick occurs PRESCALE cycles later.
//  Reset (async assert, sync release via iClk domain):
//   - DUTY shadow/active = 0, CTRL = 0, pre = 0, phase = 0
//   - oInPort = 8'h00, oLed = 0
//  Reset mid-period: all state cleared immediately. No partial update survives.
// TESTING
//  1 Reset: iResetN=0 mid-run -> oLed=0, oInPort=0, STATUS reads 0 after release.
//  2 Write DUTY0=8'h40, CTRL=1, PRESCALE=1 -> oLed[0] high 64 of every 256 cycles.
//    Read port 0 -> 8'h40 one cycle later.
//  3 Change DUTY0 to 8'hC0 at phase 100 -> current period still 64 high; next period 192 high.
//  4 DUTY1=0 and DUTY2=255 -> oLed[1] never high; oLed[2] low exactly 1 step per period.
//  5 CTRL=3 (INV) with DUTY0=0 -> oLed[0] constant 1. CTRL=2 -> all oLed=1, phase frozen.
//  6 OUTPUTK to port 8'hF0|NUM_LEDS (BASE_PORT=0) -> CTRL written. Unmapped port write
//    -> no state change, reads 8'h00.

Source files
------------

// File: rtl/picoblaze_led_pwm.sv
// picoblaze_led_pwm: kcpsm6 output-port peripheral with per-LED 8-bit duty registers,
// double-buffered (shadow/active) so duty changes apply only at PWM period boundaries.
module picoblaze_led_pwm #(
    parameter int unsigned NUM_LEDS  = 8,
    parameter logic [7:0]  BASE_PORT = 8'h00,
    parameter int unsigned PRESCALE  = 16
) (
    input  logic                iClk,
    input  logic                iResetN,
    input  logic [7:0]          iPortId,
    input  logic [7:0]          iOutPort,
    input  logic                iWriteStrobe,
    input  logic                iKWriteStrobe,
    output logic [7:0]          oInPort,
    output logic [NUM_LEDS-1:0] oLed
);

    localparam int unsigned PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CTRL_OFF = NUM_LEDS;
    localparam int unsigned STAT_OFF = NUM_LEDS + 1;

    logic [7:0]          duty_q [NUM_LEDS];
    logic [7:0]          duty_d [NUM_LEDS];
    logic [7:0]          act_q  [NUM_LEDS];
    logic [7:0]          act_d  [NUM_LEDS];
    logic [1:0]          ctrl_q, ctrl_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [7:0]          phase_q, phase_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [7:0]          in_port_q, in_port_d;

    logic                wr_en;
    logic [7:0]          wr_off;
    logic [7:0]          rd_off;
    logic                en;
    logic                tick;
    logic                wrap;

    assign en     = ctrl_q[0];
    assign tick   = en && (pre_q == PRE_W'(PRESCALE - 1));
    assign wrap   = tick && (phase_q == 8'hFF);
    assign rd_off = iPortId - BASE_PORT;

    // Write decode: OUTPUT uses the full port_id, OUTPUTK only the low nibble; OUTPUT wins.
    always_comb begin
        wr_en  = 1'b0;
        wr_off = 8'h00;
        if (iWriteStrobe) begin
            wr_en  = 1'b1;
            wr_off = iPortId - BASE_PORT;
        end else if (iKWriteStrobe) begin
            wr_en  = 1'b1;
            wr_off = {4'h0, 4'(iPortId[3:0] - BASE_PORT[3:0])};
        end
    end

    // Next-state for registers, prescaler, phase, active duties, LEDs and read data.
    always_comb begin
        duty_d    = duty_q;
        act_d     = act_q;
        ctrl_d    = ctrl_q;
        pre_d     = pre_q;
        phase_d   = phase_q;
        led_d     = '0;
        in_port_d = 8'h00;

        for (int i = 0; i < NUM_LEDS; i++) begin
            if (wr_en && (wr_off == 8'(i))) begin
                duty_d[i] = iOutPort;
            end
        end
        if (wr_en && (wr_off == 8'(CTRL_OFF))) begin
            ctrl_d = iOutPort[1:0];
        end

        if (!en) begin
            pre_d   = '0;
            phase_d = 8'h00;
        end else if (tick) begin
            pre_d   = '0;
            phase_d = phase_q + 8'd1;
        end else begin
            pre_d   = pre_q + PRE_W'(1);
        end

        // Shadows reach the active set only at a period wrap (or continuously while disabled);
        // a write in the wrap cycle is not yet visible in duty_q, so it waits a full period.
        if (!en || wrap) begin
            act_d = duty_q;
        end

        for (int i = 0; i < NUM_LEDS; i++) begin
            led_d[i] = (en && (phase_q < act_q[i])) ^ ctrl_q[1];
        end

        for (int i = 0; i < NUM_LEDS; i++) begin
            if (rd_off == 8'(i)) begin
                in_port_d = duty_q[i];
            end
        end
        if (rd_off == 8'(CTRL_OFF)) begin
            in_port_d = {6'b0, ctrl_q};
        end
        if (rd_off == 8'(STAT_OFF)) begin
            in_port_d = phase_q;
        end
    end

    // State registers, all cleared by async reset.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                duty_q[i] <= 8'h00;
                act_q[i]  <= 8'h00;
            end
            ctrl_q    <= 2'b00;
            pre_q     <= '0;
            phase_q   <= 8'h00;
            led_q     <= '0;
            in_port_q <= 8'h00;
        end else begin
            duty_q    <= duty_d;
            act_q     <= act_d;
            ctrl_q    <= ctrl_d;
            pre_q     <= pre_d;
            phase_q   <= phase_d;
            led_q     <= led_d;
            in_port_q <= in_port_d;
        end
    end

    assign oInPort = in_port_q;
    assign oLed    = led_q;

endmodule

// File: tb/tb_picoblaze_led_pwm.sv
// Directed bench for picoblaze_led_pwm: register map vectors plus PWM period sequences.
module tb_picoblaze_led_pwm;

    localparam int unsigned NL = 8;

    logic          iClk;
    logic          iResetN;
    logic [7:0]    iPortId;
    logic [7:0]    iOutPort;
    logic          iWriteStrobe;
    logic          iKWriteStrobe;
    logic [7:0]    oInPort;
    logic [NL-1:0] oLed;

    picoblaze_led_pwm #(
        .NUM_LEDS (NL),
        .BASE_PORT(8'h00),
        .PRESCALE (1)
    ) dut (
        .iClk         (iClk),
        .iResetN      (iResetN),
        .iPortId      (iPortId),
        .iOutPort     (iOutPort),
        .iWriteStrobe (iWriteStrobe),
        .iKWriteStrobe(iKWriteStrobe),
        .oInPort      (oInPort),
        .oLed         (oLed)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic [7:0] port;
        logic [7:0] data;
        bit         k;
        logic [7:0] rd;
        logic [7:0] exp_rd;
        logic [7:0] exp_led;
    } vec_t;

    vec_t       vecs [14];
    int         checks;
    int         failures;
    int         cnt_a [NL];
    int         cnt_b [NL];
    logic       bit63;
    logic       bit64;
    logic [7:0] status256;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; one write strobe cycle, returns at the following negedge.
    task automatic bus_write(input logic [7:0] port, input logic [7:0] data, input bit k);
        iPortId       = port;
        iOutPort      = data;
        iWriteStrobe  = !k;
        iKWriteStrobe = k;
        @(negedge iClk);
        iWriteStrobe  = 1'b0;
        iKWriteStrobe = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] port, output logic [7:0] data);
        iPortId = port;
        @(negedge iClk);
        data = oInPort;
    endtask

    // Align to phase 0 via STATUS, then count LED high samples over two full periods.
    task automatic run_periods(input bit do_wr, input logic [7:0] wdata);
        int guard;
        bit found;
        iPortId = 8'h09;
        found   = 1'b0;
        guard   = 0;
        while (!found && guard < 600) begin
            @(negedge iClk);
            guard++;
            if (oInPort == 8'h00) found = 1'b1;
        end
        check("sync_phase0", 32'(found), 32'd1);
        for (int b = 0; b < NL; b++) begin
            cnt_a[b] = 0;
            cnt_b[b] = 0;
        end
        for (int k = 0; k < 512; k++) begin
            for (int b = 0; b < NL; b++) begin
                if (oLed[b]) begin
                    if (k < 256) cnt_a[b]++;
                    else         cnt_b[b]++;
                end
            end
            if (k == 63)  bit63 = oLed[0];
            if (k == 64)  bit64 = oLed[0];
            if (k == 256) status256 = oInPort;
            if (do_wr && k == 100) begin
                iPortId      = 8'h00;
                iOutPort     = wdata;
                iWriteStrobe = 1'b1;
            end
            if (do_wr && k == 101) begin
                iWriteStrobe = 1'b0;
                iPortId      = 8'h09;
            end
            @(negedge iClk);
        end
    endtask

    initial begin
        logic [7:0] rd;
        int         frozen;

        checks        = 0;
        failures      = 0;
        iResetN       = 1'b1;
        iPortId       = 8'h00;
        iOutPort      = 8'h00;
        iWriteStrobe  = 1'b0;
        iKWriteStrobe = 1'b0;

        //            port   data   k   rd     exp_rd exp_led
        vecs[0]  = '{8'h00, 8'h40, 0, 8'h00, 8'h40, 8'h00};
        vecs[1]  = '{8'h03, 8'hA5, 0, 8'h03, 8'hA5, 8'h00};
        vecs[2]  = '{8'h07, 8'hFF, 0, 8'h07, 8'hFF, 8'h00};
        vecs[3]  = '{8'hF5, 8'h33, 1, 8'h05, 8'h33, 8'h00};
        vecs[4]  = '{8'h13, 8'h99, 1, 8'h03, 8'h99, 8'h00};
        vecs[5]  = '{8'h13, 8'h12, 0, 8'h03, 8'h99, 8'h00};
        vecs[6]  = '{8'h09, 8'h55, 0, 8'h09, 8'h00, 8'h00};
        vecs[7]  = '{8'h0A, 8'h77, 0, 8'h0A, 8'h00, 8'h00};
        vecs[8]  = '{8'h80, 8'h11, 0, 8'h00, 8'h40, 8'h00};
        vecs[9]  = '{8'h08, 8'hFC, 0, 8'h08, 8'h00, 8'h00};
        vecs[10] = '{8'hF8, 8'hFE, 1, 8'h08, 8'h02, 8'hFF};
        vecs[11] = '{8'h08, 8'h00, 0, 8'h08, 8'h00, 8'h00};
        vecs[12] = '{8'hFA, 8'h44, 1, 8'h0A, 8'h00, 8'h00};
        vecs[13] = '{8'h0F, 8'h01, 0, 8'h07, 8'hFF, 8'h00};

        // Power-on reset
        #1 iResetN = 1'b0;
        #1;
        check("reset_led", 32'(oLed), 32'h0);
        check("reset_inport", 32'(oInPort), 32'h0);
        repeat (3) @(negedge iClk);
        iResetN = 1'b1;
        @(negedge iClk);

        // Register map vectors with PWM disabled
        for (int i = 0; i < 14; i++) begin
            bus_write(vecs[i].port, vecs[i].data, vecs[i].k);
            bus_read(vecs[i].rd, rd);
            check($sformatf("vec%0d_rd", i), 32'(rd), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d_led", i), 32'(oLed), 32'(vecs[i].exp_led));
        end

        // Read latency is exactly one cycle
        iPortId = 8'h0A;
        @(negedge iClk);
        iPortId = 8'h00;
        #1;
        check("rd_latency_before", 32'(oInPort), 32'h00);
        @(negedge iClk);
        check("rd_latency_after", 32'(oInPort), 32'h40);

        // Enable with PRESCALE=1: phase advances one step per cycle
        bus_write(8'h01, 8'h00, 1'b0);
        bus_write(8'h02, 8'hFF, 1'b0);
        bus_write(8'h08, 8'h01, 1'b0);
        iPortId = 8'h09;
        for (int i = 0; i < 4; i++) begin
            @(negedge iClk);
            check($sformatf("phase_step%0d", i), 32'(oInPort), 32'(i));
        end

        // Steady-state duty cycles
        run_periods(1'b0, 8'h00);
        check("duty40_p1", 32'(cnt_a[0]), 32'd64);
        check("duty40_p2", 32'(cnt_b[0]), 32'd64);
        check("duty40_ph63_on", 32'(bit63), 32'd1);
        check("duty40_ph64_off", 32'(bit64), 32'd0);
        check("duty00_never", 32'(cnt_a[1] + cnt_b[1]), 32'd0);
        check("dutyFF_p1", 32'(cnt_a[2]), 32'd255);
        check("duty99_p1", 32'(cnt_a[3]), 32'd153);
        check("duty33_p1", 32'(cnt_a[5]), 32'd51);
        check("status_wrap", 32'(status256), 32'h00);

        // Mid-period duty change waits for the next period
        run_periods(1'b1, 8'hC0);
        check("midchg_cur", 32'(cnt_a[0]), 32'd64);
        check("midchg_next", 32'(cnt_b[0]), 32'd192);

        // Inverted outputs
        bus_write(8'h00, 8'h00, 1'b0);
        bus_write(8'h08, 8'h03, 1'b0);
        run_periods(1'b0, 8'h00);
        check("inv_duty0", 32'(cnt_a[0]), 32'd256);
        check("inv_duty00", 32'(cnt_a[1]), 32'd256);
        check("inv_dutyFF", 32'(cnt_a[2]), 32'd1);

        // Disabled with INV: all LEDs high, phase frozen at 0
        bus_write(8'h08, 8'h02, 1'b0);
        iPortId = 8'h09;
        repeat (2) @(negedge iClk);
        frozen = 0;
        for (int i = 0; i < 16; i++) begin
            if (oLed == 8'hFF && oInPort == 8'h00) frozen++;
            @(negedge iClk);
        end
        check("disabled_frozen", 32'(frozen), 32'd16);

        // OUTPUTK into CTRL, unmapped full write ignored
        bus_write(8'hF8, 8'h01, 1'b1);
        bus_read(8'h08, rd);
        check("k_ctrl", 32'(rd), 32'h01);
        bus_write(8'h0B, 8'h5A, 1'b0);
        bus_read(8'h0B, rd);
        check("unmapped_rd", 32'(rd), 32'h00);
        bus_read(8'h08, rd);
        check("unmapped_ctrl", 32'(rd), 32'h01);
        bus_read(8'h00, rd);
        check("unmapped_duty0", 32'(rd), 32'h00);

        // Reset while running
        repeat (40) @(negedge iClk);
        iPortId = 8'h07;
        @(negedge iClk);
        check("pre_reset_rd", 32'(oInPort), 32'hFF);
        iResetN = 1'b0;
        #1;
        check("midrst_led", 32'(oLed), 32'h0);
        check("midrst_inport", 32'(oInPort), 32'h0);
        repeat (2) @(negedge iClk);
        iResetN = 1'b1;
        bus_read(8'h09, rd);
        check("midrst_status", 32'(rd), 32'h00);
        bus_read(8'h07, rd);
        check("midrst_duty7", 32'(rd), 32'h00);
        bus_read(8'h08, rd);
        check("midrst_ctrl", 32'(rd), 32'h00);
        check("midrst_led_after", 32'(oLed), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
